// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD / seven-segment decoder.
// Holds the FSM encoding, segment code table and double-dabble adjust constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned SEG_W = 7;

  // Active-low codes, bit 6 = segment a ... bit 0 = segment g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Digit to segment code; non-decimal nibbles show blank.
  function automatic logic [SEG_W-1:0] seg7_code(input logic [3:0] digit);
    logic [SEG_W-1:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_seq_decoder_if.sv
// Start/busy/done handshake and result bus of the sequential BCD decoder.
interface bcd_seq_decoder_if #(
  parameter int unsigned N      = 10,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned SEG    = 7
);

  logic                    start;
  logic [N-1:0]            bin_in;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  logic [4*DIGITS-1:0]     bcd_out;
  logic [SEG*DIGITS-1:0]   seg_out;

  modport master (
    output start, bin_in,
    input  busy, done, ovf, bcd_out, seg_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ovf, bcd_out, seg_out
  );

endinterface

// File: rtl/seg7_encoder.sv
// One-digit active-low seven-segment encoder with forced-blank input.
module seg7_encoder
  import bcd_pkg::*;
#(
  parameter int unsigned SEG = 7
) (
  input  logic [3:0]     digit,
  input  logic           blank,
  output logic [SEG-1:0] seg_c
);

  always_comb begin
    seg_c = SEG'(SEG_BLANK);
    if (!blank) seg_c = SEG'(seg7_code(digit));
  end

endmodule

// File: rtl/bcd_seq_decoder.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with registered BCD, seven-segment and overflow results.
module bcd_seq_decoder
  import bcd_pkg::*;
#(
  parameter int unsigned N        = 10,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SEG      = 7,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic               clk,
  input  logic               rst,
  bcd_seq_decoder_if.slave   bus
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = BW + N;
  localparam int unsigned CW = $clog2(N + 1);

  state_t                state;
  logic [SW-1:0]         sh;
  logic [CW-1:0]         cnt;
  logic                  acc;

  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [BW-1:0]         bcd_q;
  logic [SEG*DIGITS-1:0] seg_q;

  logic [SW-1:0]         adj;
  logic [SW-1:0]         sh_nxt;
  logic                  carry;
  logic [BW-1:0]         bcd_nxt;
  logic [DIGITS-1:0]     blank;
  logic [SEG*DIGITS-1:0] seg_nxt;

  // One double-dabble step: adjust every BCD nibble, then shift left by one.
  always_comb begin
    adj = sh;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (adj[N+4*d +: 4] >= ADJ_THRESH)
        adj[N+4*d +: 4] = adj[N+4*d +: 4] + ADJ_ADD;
    end
    carry   = adj[SW-1];
    sh_nxt  = {adj[SW-2:0], 1'b0};
    bcd_nxt = sh_nxt[SW-1:N];
  end

  // Leading-zero blanking scans from the most significant digit down.
  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
      nz       = nz | (bcd_nxt[4*d +: 4] != 4'd0);
      blank[d] = (BLANK_LZ != 0) && (d != 0) && !nz;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encoder #(.SEG(SEG)) u_enc (
      .digit (bcd_nxt[4*g +: 4]),
      .blank (blank[g]),
      .seg_c (seg_nxt[SEG*g +: SEG])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      acc    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      bcd_q  <= '0;
      seg_q  <= '1;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sh     <= {BW'(0), bus.bin_in};
            cnt    <= CW'(N);
            acc    <= 1'b0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sh  <= sh_nxt;
          cnt <= cnt - CW'(1);
          acc <= acc | carry;
          // Final shift publishes the result directly from the step logic.
          if (cnt == CW'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            bcd_q  <= bcd_nxt;
            seg_q  <= seg_nxt;
            ovf_q  <= acc | carry;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_q;
  assign bus.seg_out = seg_q;

endmodule

// File: tb/tb_bcd_seq_decoder.sv
// Bench for bcd_seq_decoder: three configurations driven in lockstep and
// compared against an arithmetic decimal-digit reference.
module tb_bcd_seq_decoder;

  localparam int unsigned N = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bcd_seq_decoder_if #(.N(N), .DIGITS(4), .SEG(7)) ifa ();
  bcd_seq_decoder_if #(.N(N), .DIGITS(4), .SEG(7)) ifb ();
  bcd_seq_decoder_if #(.N(N), .DIGITS(3), .SEG(7)) ifc ();

  bcd_seq_decoder #(.N(N), .DIGITS(4), .SEG(7), .BLANK_LZ(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  bcd_seq_decoder #(.N(N), .DIGITS(4), .SEG(7), .BLANK_LZ(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  bcd_seq_decoder #(.N(N), .DIGITS(3), .SEG(7), .BLANK_LZ(0)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic logic [6:0] seg_ref(int unsigned dg);
    case (dg)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] bcd_ref(int unsigned v, int unsigned nd);
    logic [15:0] r = '0;
    int unsigned p = 1;
    for (int unsigned d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] segs_ref(int unsigned v, int unsigned nd, bit blz);
    logic [27:0] r = '0;
    int unsigned p = 1;
    int unsigned m = v % (10 ** nd);
    for (int unsigned d = 0; d < nd; d++) begin
      if (blz && d > 0 && m < p) r[7*d +: 7] = 7'b1111111;
      else                       r[7*d +: 7] = seg_ref((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic drive(bit s, int unsigned v);
    ifa.start = s; ifb.start = s; ifc.start = s;
    ifa.bin_in = N'(v); ifb.bin_in = N'(v); ifc.bin_in = N'(v);
  endtask

  task automatic check_results(string tag, int unsigned v);
    chk({tag, "_bcd_a"}, 64'(ifa.bcd_out), 64'(bcd_ref(v, 4)));
    chk({tag, "_ovf_a"}, 64'(ifa.ovf), 64'(v >= 10000));
    chk({tag, "_seg_a"}, 64'(ifa.seg_out), 64'(segs_ref(v, 4, 1'b0)));
    chk({tag, "_bcd_b"}, 64'(ifb.bcd_out), 64'(bcd_ref(v, 4)));
    chk({tag, "_seg_b"}, 64'(ifb.seg_out), 64'(segs_ref(v, 4, 1'b1)));
    chk({tag, "_bcd_c"}, 64'(ifc.bcd_out), 64'(bcd_ref(v, 3)));
    chk({tag, "_ovf_c"}, 64'(ifc.ovf), 64'(v >= 1000));
    chk({tag, "_seg_c"}, 64'(ifc.seg_out), 64'(segs_ref(v, 3, 1'b0)));
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_busy"}, 64'({ifa.busy, ifb.busy, ifc.busy}), 64'(0));
    chk({tag, "_done"}, 64'({ifa.done, ifb.done, ifc.done}), 64'(0));
    chk({tag, "_ovf"},  64'({ifa.ovf, ifb.ovf, ifc.ovf}), 64'(0));
    chk({tag, "_bcd"},  64'({ifa.bcd_out, ifb.bcd_out, ifc.bcd_out}), 64'(0));
    chk({tag, "_seg_a"}, 64'(ifa.seg_out), 64'(28'hFFFFFFF));
    chk({tag, "_seg_c"}, 64'(ifc.seg_out), 64'(21'h1FFFFF));
  endtask

  // Called at a negedge with all DUTs idle; optionally pokes start while busy.
  task automatic run(string tag, int unsigned v, bit poke, int unsigned pv);
    int unsigned lat = 0;
    drive(1'b1, v);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, $urandom_range(0, 1023));
    chk({tag, "_busy_start"}, 64'({ifa.busy, ifb.busy, ifc.busy}), 64'(3'b111));
    for (int unsigned i = 1; i <= N + 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifa.done) begin lat = i; break; end
      if (poke && i == 3) drive(1'b1, pv);
      else if (poke && i == 4) drive(1'b0, pv);
    end
    chk({tag, "_latency"}, 64'(lat), 64'(N));
    chk({tag, "_done_all"}, 64'({ifb.done, ifc.done, ifa.busy}), 64'(3'b110));
    check_results(tag, v);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'({ifa.done, ifb.done, ifc.done}), 64'(0));
  endtask

  initial begin
    int unsigned dq[$];
    int unsigned dir[8] = '{1023, 0, 7, 999, 1000, 9, 10, 100};
    drive(1'b0, 0);
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_vals("idle");

    foreach (dir[i]) run($sformatf("dir%0d", dir[i]), dir[i], 1'b0, 0);

    // start pulsed while busy with another value must be ignored
    run("poke", 321, 1'b1, 876);
    repeat (3) @(negedge clk);
    chk("poke_no_restart", 64'({ifa.busy, ifa.done}), 64'(0));

    // start held high: a conversion every N+2 cycles
    drive(1'b1, 500);
    for (int unsigned t = 1; t <= 3 * (N + 2); t++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifa.done) dq.push_back(t);
    end
    drive(1'b0, 500);
    chk("b2b_count", 64'(dq.size()), 64'(3));
    if (dq.size() == 3) begin
      chk("b2b_first", 64'(dq[0]), 64'(N + 1));
      chk("b2b_gap1", 64'(dq[1] - dq[0]), 64'(N + 2));
      chk("b2b_gap2", 64'(dq[2] - dq[1]), 64'(N + 2));
    end
    check_results("b2b", 500);
    repeat (3) @(negedge clk);

    // leave overflow and nonzero results, then reset mid-conversion
    run("pre_abort", 1023, 1'b0, 0);
    @(negedge clk);
    drive(1'b1, 456);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 456);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("abort_imm");
    @(negedge clk);
    rst = 1'b0;
    begin
      int unsigned seen = 0;
      for (int unsigned i = 0; i < N + 4; i++) begin
        @(negedge clk);
        if (ifa.done || ifb.done || ifc.done || ifa.busy) seen++;
      end
      chk("abort_no_done", 64'(seen), 64'(0));
    end
    check_reset_vals("abort_after");

    for (int k = 0; k < 1000; k++) run("rnd", $urandom_range(0, 1023), 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
